// File: rtl/tcm_mem_initiator.sv
// Tightly-coupled-memory request initiator: issues 32-bit lane accesses to a
// 64-bit synchronous RAM and returns in-order responses through a 2-entry FIFO.
module tcm_mem_initiator #(
  parameter int TAG_W      = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  input  logic [15:0]      req_addr_i,
  input  logic             req_rd_i,
  input  logic [3:0]       req_wr_i,
  input  logic [31:0]      req_data_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             req_accept_o,
  output logic             resp_valid_o,
  output logic [31:0]      resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  input  logic             resp_ready_i,
  output logic [12:0]      ram_addr_o,
  output logic [63:0]      ram_data_o,
  output logic [7:0]       ram_wr_o,
  input  logic [63:0]      ram_data_i
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic             infl_vld_q;
  logic             infl_lane_q;
  logic             infl_rd_q;
  logic [TAG_W-1:0] infl_tag_q;

  logic [31:0]      fifo_data_q [2];
  logic [TAG_W-1:0] fifo_tag_q  [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CNT_W-1:0] occ;
  logic             push, pop, accept, is_wr;
  logic [31:0]      push_data;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr_i[1:0];

  // A pop in the same cycle frees a slot, so a full pipe still accepts.
  assign occ    = cnt_q + CNT_W'(infl_vld_q);
  assign pop    = resp_valid_o && resp_ready_i;
  assign accept = rst_ni && req_valid_i && ((occ < CNT_W'(RESP_DEPTH)) || pop);
  assign is_wr  = |req_wr_i;
  assign push   = infl_vld_q;

  assign req_accept_o = accept;
  assign ram_addr_o   = req_addr_i[15:3];
  assign ram_data_o   = {req_data_i, req_data_i};
  assign ram_wr_o     = (accept && is_wr) ?
                        (req_addr_i[2] ? {req_wr_i, 4'h0} : {4'h0, req_wr_i}) : 8'h00;

  assign push_data = infl_rd_q ? (infl_lane_q ? ram_data_i[63:32] : ram_data_i[31:0])
                               : 32'h0;

  assign resp_valid_o = (cnt_q != '0);
  assign resp_data_o  = resp_valid_o ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign resp_tag_o   = resp_valid_o ? fifo_tag_q[rd_ptr_q]  : '0;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_vld_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      infl_vld_q <= accept;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      cnt_q      <= cnt_d;
    end
  end

  // Payload registers carry no reset; their valid qualifiers above do.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      infl_tag_q  <= req_tag_i;
      infl_lane_q <= req_addr_i[2];
      infl_rd_q   <= req_rd_i && !is_wr;
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_tag_q[wr_ptr_q]  <= infl_tag_q;
    end
  end

endmodule

// File: tb/tb_tcm_mem_initiator.sv
// Scoreboard bench for tcm_mem_initiator with a read-first 64-bit RAM model.
module tb_tcm_mem_initiator;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             req_valid;
  logic [15:0]      req_addr;
  logic             req_rd;
  logic [3:0]       req_wr;
  logic [31:0]      req_data;
  logic [TAG_W-1:0] req_tag;
  logic             req_accept_o;
  logic             resp_valid_o;
  logic [31:0]      resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             resp_ready;
  logic [12:0]      ram_addr_o;
  logic [63:0]      ram_data_o;
  logic [7:0]       ram_wr_o;
  logic [63:0]      ram_rdata;

  tcm_mem_initiator #(.TAG_W(TAG_W), .RESP_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_rd_i(req_rd),
    .req_wr_i(req_wr), .req_data_i(req_data), .req_tag_i(req_tag),
    .req_accept_o(req_accept_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o),
    .resp_ready_i(resp_ready),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
    .ram_data_i(ram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  int acc_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // RAM: registered read of the old word, byte-enabled write, same edge.
  logic [63:0] ram_mem [8192];
  initial begin
    for (int i = 0; i < 8192; i++) ram_mem[i] = 64'h0;
    ram_rdata = 64'h0;
  end
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++)
      if (ram_wr_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
    ram_rdata <= ram_mem[ram_addr_o];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: 32-bit lanes keyed by addr[15:2], updated in acceptance order.
  logic [31:0] ref_mem [int];
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               cyc;
  } exp_t;
  exp_t sb[$];

  logic       exp_vld, exp_pop, exp_acc;
  logic [7:0] exp_wr;
  exp_t       e;
  int         key;

  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("rst_accept", req_accept_o, 0);
      chk("rst_resp_valid", resp_valid_o, 0);
      chk("rst_resp_data", resp_data_o, 0);
      chk("rst_resp_tag", resp_tag_o, 0);
      chk("rst_ram_wr", ram_wr_o, 0);
      sb.delete();
    end else begin
      exp_vld = (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
      chk("resp_valid", resp_valid_o, exp_vld);
      if (exp_vld) begin
        chk("resp_tag", resp_tag_o, sb[0].tag);
        chk("resp_data", resp_data_o, sb[0].data);
      end
      exp_pop = exp_vld && resp_ready;
      exp_acc = req_valid && ((sb.size() < 2) || exp_pop);
      exp_wr  = (exp_acc && req_wr != 4'h0) ?
                (req_addr[2] ? {req_wr, 4'h0} : {4'h0, req_wr}) : 8'h00;
      chk("req_accept", req_accept_o, exp_acc);
      chk("ram_addr", ram_addr_o, req_addr[15:3]);
      chk("ram_data", ram_data_o, {req_data, req_data});
      chk("ram_wr", ram_wr_o, exp_wr);
      if (exp_pop) begin
        void'(sb.pop_front());
        n_pop++;
      end
      if (exp_acc) begin
        key = int'(req_addr[15:2]);
        if (!ref_mem.exists(key)) ref_mem[key] = 32'h0;
        e.tag  = req_tag;
        e.cyc  = cyc;
        e.data = 32'h0;
        if (req_wr != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (req_wr[b]) ref_mem[key][8*b +: 8] = req_data[8*b +: 8];
        end else if (req_rd) begin
          e.data = ref_mem[key];
        end
        sb.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic rd, input logic [3:0] wr,
                       input logic [31:0] d, input logic [TAG_W-1:0] t,
                       input logic [7:0] wr_exp, output int waits);
    req_valid = 1'b1; req_addr = a; req_rd = rd; req_wr = wr; req_data = d; req_tag = t;
    waits = 0;
    @(negedge clk);
    while (!req_accept_o && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 50) chk("accept_timeout", 0, 1);
    chk("ram_wr_dir", ram_wr_o, wr_exp);
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_resp(input logic [TAG_W-1:0] t, input logic [31:0] d, input bit lat);
    int n = 0;
    @(negedge clk);
    while (!resp_valid_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("resp_seen", resp_valid_o, 1);
    chk("dir_tag", resp_tag_o, t);
    chk("dir_data", resp_data_o, d);
    if (lat) chk("latency", cyc - acc_cyc, 2);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  int w, a0, p0;

  initial begin
    rst_ni = 1'b0; resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 16'h0014; req_rd = 1'b0; req_wr = 4'hF;
    req_data = 32'h0; req_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    issue(16'h0014, 1'b0, 4'hF, 32'hDEADBEEF, 4'd1, 8'hF0, w);
    chk("first_accept_wait", w, 0);
    chk("ram_addr_dir", ram_addr_o, 13'h002);
    expect_resp(4'd1, 32'h0, 1);
    issue(16'h0010, 1'b0, 4'hF, 32'h12345678, 4'd2, 8'h0F, w);
    expect_resp(4'd2, 32'h0, 1);
    issue(16'h0014, 1'b1, 4'h0, 32'h0, 4'd3, 8'h00, w);
    expect_resp(4'd3, 32'hDEADBEEF, 1);
    issue(16'h0010, 1'b1, 4'h0, 32'h0, 4'd4, 8'h00, w);
    expect_resp(4'd4, 32'h12345678, 1);

    issue(16'h0020, 1'b0, 4'hF, 32'hA5A55A5A, 4'd5, 8'h0F, w);
    issue(16'h0020, 1'b1, 4'h0, 32'h0, 4'd6, 8'h00, w);
    expect_resp(4'd5, 32'h0, 0);
    expect_resp(4'd6, 32'hA5A55A5A, 0);

    issue(16'h0008, 1'b1, 4'h3, 32'hFFFFFFFF, 4'd7, 8'h03, w);
    expect_resp(4'd7, 32'h0, 1);
    issue(16'h000C, 1'b0, 4'h0, 32'hCAFEF00D, 4'd8, 8'h00, w);
    expect_resp(4'd8, 32'h0, 1);
    issue(16'h0008, 1'b1, 4'h0, 32'h0, 4'd9, 8'h00, w);
    expect_resp(4'd9, 32'h0000FFFF, 1);

    resp_ready = 1'b0; a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 16'h0014; req_rd = 1'b1; req_wr = 4'h0;
      req_tag = TAG_W'(8 + i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("stall_accepts", n_acc - a0, 2);
    repeat (3) @(posedge clk);
    #1 chk("stall_hold_valid", resp_valid_o, 1);
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("stall_drained", n_pop - p0, 2);
    chk("stall_sb_empty", sb.size(), 0);

    a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 16'h0010; req_rd = 1'b1; req_wr = 4'h0;
      req_tag = TAG_W'(i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("stream_accepts", n_acc - a0, 8);
    chk("stream_pops", n_pop - p0, 8);

    for (int i = 0; i < 120; i++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = 16'($urandom_range(0, 7)) << 2;
      req_rd     = 1'($urandom_range(0, 1));
      req_wr     = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      req_data   = $urandom;
      req_tag    = TAG_W'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("rand_sb_empty", sb.size(), 0);

    resp_ready = 1'b0;
    issue(16'h0014, 1'b1, 4'h0, 32'h0, 4'd10, 8'h00, w);
    issue(16'h0010, 1'b1, 4'h0, 32'h0, 4'd11, 8'h00, w);
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_valid", resp_valid_o, 1);
    p0 = n_pop;
    rst_ni = 1'b0;
    #1 chk("async_rst_valid", resp_valid_o, 0);
    chk("async_rst_tag", resp_tag_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1; resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("no_stale_valid", resp_valid_o, 0);
    chk("no_stale_pops", n_pop - p0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
